// File: rtl/dds_pwr_sequencer.sv
// dds_pwr_sequencer: arbitrated power-down sequencer for DDS1..DDS3.
// Two requesters (bit0 = PS control path, bit1 = sweep controller) each ask
// for a power-down/re-init cycle on a subset of channels. One request is
// served at a time. Each selected channel is pulsed low-to-high-to-low in
// ascending order, with a settle gap between channels to limit inrush.
//
// Optional feature macro: DDS_PWR_ABORT_EN adds the abort input and the
// aborted status output. Without it every sequence runs to completion.
//
// Handshake: req[i] is a level held by requester i until it sees ack[i].
// A request present in IDLE is granted (round robin on a tie). After the
// grant, req and the masks are not looked at again until the sequence ends.
// ack[i] is a single-cycle pulse, and the requester must drop req[i] in that
// same cycle, otherwise the next IDLE cycle treats it as a new request.
module dds_pwr_sequencer #(
  parameter int PULSE_CYCLES = 4000,
  parameter int GAP_CYCLES   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [2:0] mask0,
  input  logic [2:0] mask1,
`ifdef DDS_PWR_ABORT_EN
  input  logic       abort,
  output logic       aborted,
`endif
  output logic [1:0] ack,
  output logic       busy,
  output logic       grant_id,
  output logic [2:0] o_dds_pwr_down,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_PULSE  = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Counter terminal values; the counter starts at 0 so the last count is N-1.
  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);
  localparam bit          GAP_EN     = (GAP_CYCLES != 0);

  logic [2:0]  state;
  logic [2:0]  rem_mask;
  logic [15:0] cnt;
  logic        last_grant;
  logic        grant_sel;
  logic [2:0]  pick_oh;
  logic        abort_hit;

  assign state_dbg = state;

  // Requester choice in IDLE: a lone request wins, a tie goes to the one not served last.
  always_comb begin
    grant_sel = 1'b0;
    if (req == 2'b10)      grant_sel = 1'b1;
    else if (req == 2'b11) grant_sel = ~last_grant;
  end

  // Lowest remaining channel as a one-hot vector (two's-complement trick).
  always_comb begin
    pick_oh = rem_mask & (~rem_mask + 3'd1);
  end

`ifdef DDS_PWR_ABORT_EN
  logic abort_flag;

  assign abort_hit = abort && ((state == S_SELECT) || (state == S_PULSE) || (state == S_GAP));

  // Remember an abort for the ack cycle; status is held until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abort_flag <= 1'b0;
      aborted    <= 1'b0;
    end else if ((state == S_IDLE) && (|req)) begin
      abort_flag <= 1'b0;
      aborted    <= 1'b0;
    end else if (abort_hit) begin
      abort_flag <= 1'b1;
    end else if (state == S_DONE) begin
      aborted <= abort_flag;
    end
  end
`else
  assign abort_hit = 1'b0;
`endif

  // Main sequencer: grant, walk the latched mask, pulse, gap, acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      rem_mask       <= 3'b000;
      cnt            <= 16'd0;
      ack            <= 2'b00;
      busy           <= 1'b0;
      grant_id       <= 1'b0;
      last_grant     <= 1'b1;
      o_dds_pwr_down <= 3'b000;
    end else begin
      ack <= 2'b00;
      case (state)
        S_IDLE: begin
          busy <= |req;
          if (|req) begin
            grant_id   <= grant_sel;
            last_grant <= grant_sel;
            rem_mask   <= grant_sel ? mask1 : mask0;
            state      <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (abort_hit || (rem_mask == 3'b000)) begin
            rem_mask       <= 3'b000;
            o_dds_pwr_down <= 3'b000;
            state          <= S_DONE;
          end else begin
            rem_mask       <= rem_mask & ~pick_oh;
            o_dds_pwr_down <= pick_oh;
            cnt            <= 16'd0;
            state          <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (abort_hit) begin
            rem_mask       <= 3'b000;
            o_dds_pwr_down <= 3'b000;
            state          <= S_DONE;
          end else if (cnt == PULSE_LAST) begin
            o_dds_pwr_down <= 3'b000;
            cnt            <= 16'd0;
            state          <= GAP_EN ? S_GAP : S_SELECT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (abort_hit) begin
            rem_mask <= 3'b000;
            state    <= S_DONE;
          end else if (cnt == GAP_LAST) begin
            cnt   <= 16'd0;
            state <= S_SELECT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          ack   <= grant_id ? 2'b10 : 2'b01;
          state <= S_IDLE;
        end
        default: begin
          o_dds_pwr_down <= 3'b000;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_pwr_sequencer.sv
// Testbench for dds_pwr_sequencer with default PULSE_CYCLES/GAP_CYCLES.
// Table of request vectors plus hand-written tie, withdrawal, reset and
// (with DDS_PWR_ABORT_EN) abort sequences. Outputs sampled 1 ns after posedge.
module tb_dds_pwr_sequencer;

  localparam int P   = 4000;
  localparam int G   = 100;
  localparam int CYC = P + G + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [2:0] mask0;
  logic [2:0] mask1;
  logic [1:0] ack;
  logic       busy;
  logic       grant_id;
  logic [2:0] o_dds_pwr_down;
  logic [2:0] state_dbg;
`ifdef DDS_PWR_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int checks = 0;
  int errors = 0;

  dds_pwr_sequencer #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .mask0          (mask0),
    .mask1          (mask1),
`ifdef DDS_PWR_ABORT_EN
    .abort          (abort),
    .aborted        (aborted),
`endif
    .ack            (ack),
    .busy           (busy),
    .grant_id       (grant_id),
    .o_dds_pwr_down (o_dds_pwr_down),
    .state_dbg      (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [2:0] m0;
    logic [2:0] m1;
    logic       gid;
    logic [2:0] exp_mask;
    logic       twiddle;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected power-down lines t cycles after the grant edge for latched mask m.
  function automatic logic [2:0] exp_o(input logic [2:0] m, input int t);
    logic [2:0] res;
    int j;
    res = 3'b000;
    j = 0;
    for (int ch = 0; ch < 3; ch++) begin
      if (m[ch]) begin
        if ((t >= 1 + j * CYC) && (t <= P + j * CYC)) res[ch] = 1'b1;
        j++;
      end
    end
    return res;
  endfunction

  // Follow one granted sequence from its grant edge to its ack cycle.
  task automatic expect_seq(input logic gid, input logic [2:0] m, input logic twiddle);
    int n, ackt, bad, ft;
    logic [5:0] got, exp, fgot, fexp;
    logic [1:0] ea;
    n    = int'(m[0]) + int'(m[1]) + int'(m[2]);
    ackt = 2 + n * CYC;
    ea   = gid ? 2'b10 : 2'b01;
    bad  = 0;
    ft   = 0;
    fgot = '0;
    fexp = '0;
    for (int t = 0; t <= ackt; t++) begin
      @(posedge clk);
      #1;
      exp = {exp_o(m, t), 1'b1, (t == ackt) ? ea : 2'b00};
      got = {o_dds_pwr_down, busy, ack};
      if (got !== exp) begin
        if (bad == 0) begin
          ft = t; fgot = got; fexp = exp;
        end
        bad++;
      end
      if (t == 0) begin
        chk("grant_id", 32'(grant_id), 32'(gid));
        if (twiddle) begin
          req   = 2'b00;
          mask0 = ~mask0;
          mask1 = ~mask1;
        end
      end
      if (t == ackt) begin
        chk("ack_pulse", 32'(ack), 32'(ea));
        req = req & ~ea;
      end
    end
    if (bad != 0)
      $display("  first wave deviation at t=%0d got {o,busy,ack}=%b want %b", ft, fgot, fexp);
    chk("wave_bad_cycles", 32'(bad), 32'd0);
  endtask

  task automatic expect_idle(input string name);
    @(posedge clk);
    #1;
    chk(name, {26'd0, o_dds_pwr_down, busy, ack}, 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    rst   = 1'b1;
    req   = 2'b00;
    mask0 = 3'b000;
    mask1 = 3'b000;
`ifdef DDS_PWR_ABORT_EN
    abort = 1'b0;
`endif

    // Reset values
    #3;
    chk("reset_outputs", {26'd0, o_dds_pwr_down, busy, ack}, 32'd0);
    chk("reset_grant_id", 32'(grant_id), 32'd0);
`ifdef DDS_PWR_ABORT_EN
    chk("reset_aborted", 32'(aborted), 32'd0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Tie from reset: requester 0 first, then requester 1
    req   = 2'b11;
    mask0 = 3'b001;
    mask1 = 3'b010;
    expect_seq(1'b0, 3'b001, 1'b0);
    expect_seq(1'b1, 3'b010, 1'b0);
    expect_idle("idle_after_tie1");

    // Second tie: requester 0 wins because requester 1 was last; acks 3 cycles apart
    req   = 2'b11;
    mask0 = 3'b000;
    mask1 = 3'b000;
    expect_seq(1'b0, 3'b000, 1'b0);
    expect_seq(1'b1, 3'b000, 1'b0);
    expect_idle("idle_after_tie2");

    // Table-driven single requests
    vecs[0] = '{req: 2'b01, m0: 3'b001, m1: 3'b000, gid: 1'b0, exp_mask: 3'b001, twiddle: 1'b0};
    vecs[1] = '{req: 2'b10, m0: 3'b000, m1: 3'b111, gid: 1'b1, exp_mask: 3'b111, twiddle: 1'b0};
    vecs[2] = '{req: 2'b01, m0: 3'b000, m1: 3'b111, gid: 1'b0, exp_mask: 3'b000, twiddle: 1'b0};
    vecs[3] = '{req: 2'b10, m0: 3'b011, m1: 3'b101, gid: 1'b1, exp_mask: 3'b101, twiddle: 1'b1};
    vecs[4] = '{req: 2'b01, m0: 3'b110, m1: 3'b000, gid: 1'b0, exp_mask: 3'b110, twiddle: 1'b1};
    for (int i = 0; i < 5; i++) begin
      req   = vecs[i].req;
      mask0 = vecs[i].m0;
      mask1 = vecs[i].m1;
      expect_seq(vecs[i].gid, vecs[i].exp_mask, vecs[i].twiddle);
      expect_idle($sformatf("idle_after_vec%0d", i));
    end

    // Withdrawal: req[1] raised while busy and dropped before any grant
    req   = 2'b01;
    mask0 = 3'b000;
    @(posedge clk); #1;
    chk("wd_grant", {30'd0, busy, grant_id}, 32'b10);
    req   = 2'b11;
    mask1 = 3'b111;
    @(posedge clk); #1;
    req = 2'b01;
    @(posedge clk); #1;
    chk("wd_ack0", 32'(ack), 32'b01);
    req = 2'b00;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      chk("wd_no_ack1", {26'd0, o_dds_pwr_down, busy, ack}, 32'd0);
    end

`ifdef DDS_PWR_ABORT_EN
    // Abort during the DDS2 pulse
    req   = 2'b01;
    mask0 = 3'b111;
    @(posedge clk); #1;
    repeat (CYC + 100) @(posedge clk);
    #1;
    chk("ab_in_dds2", 32'(o_dds_pwr_down), 32'b010);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("ab_lines_low", {27'd0, o_dds_pwr_down, 2'b00} | {30'd0, ack}, 32'd0);
    @(posedge clk); #1;
    chk("ab_ack", {29'd0, aborted, ack}, 32'b101);
    req = 2'b00;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      chk("ab_after", {25'd0, aborted, o_dds_pwr_down, busy, ack}, 32'b100000);
    end
    req   = 2'b01;
    mask0 = 3'b000;
    @(posedge clk); #1;
    chk("ab_cleared_on_grant", {30'd0, aborted, busy}, 32'b01);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ab_plain_ack", {29'd0, aborted, ack}, 32'b001);
    req = 2'b00;
    expect_idle("idle_after_abort");
`endif

    // Reset during the DDS2 pulse
    req   = 2'b01;
    mask0 = 3'b111;
    @(posedge clk); #1;
    repeat (CYC + 1500) @(posedge clk);
    #1;
    chk("rst_in_dds2", 32'(o_dds_pwr_down), 32'b010);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {26'd0, o_dds_pwr_down, busy, ack}, 32'd0);
    req = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      chk("rst_no_ack", {26'd0, o_dds_pwr_down, busy, ack}, 32'd0);
    end
    chk("rst_state_idle", 32'(state_dbg), 32'd0);

    // Pointer reset again: tie goes to requester 0
    req   = 2'b11;
    mask0 = 3'b000;
    mask1 = 3'b000;
    expect_seq(1'b0, 3'b000, 1'b0);
    expect_seq(1'b1, 3'b000, 1'b0);
    expect_idle("idle_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_pwr_sequencer.md
# dds_pwr_sequencer

Arbitrated power-down sequencer for the three DDS channels. Two requesters (the PS control path and the sweep controller) each ask for a power-down/re-init cycle on any subset of channels. The block grants one request at a time and pulses each selected channel's power-down line in turn, with a settle gap between channels to limit inrush. It replaces direct PS control of the DDS power-down pins.

## Interface
- PULSE_CYCLES, 4000: power-down pulse length per channel, in clk cycles (1..65535)
- GAP_CYCLES, 100: low time after each pulse before the next channel, in clk cycles (0..65535)

- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- req  input  2  request per requester (bit0 = PS, bit1 = sweep); level, held until ack
- mask0  input  3  channel mask for requester 0, sampled at grant (bit i = DDS channel i+1)
- mask1  input  3  channel mask for requester 1, sampled at grant
- ack  output  2  one-cycle completion pulse to the granted requester
- busy  output  1  high from grant until the ack cycle inclusive
- grant_id  output  1  index of current or last granted requester
- o_dds_pwr_down  output  3  power-down lines to DDS1..DDS3; 1 = powered down
- abort  input  1  present only with DDS_PWR_ABORT_EN
- aborted  output  1  present only with DDS_PWR_ABORT_EN

## Operation
- The clock is clk. The reset is rst, asynchronous and active-high.
- Reset values: ack=0, busy=0, grant_id=0, o_dds_pwr_down=3'b000, aborted=0. The round-robin pointer is set so that requester 0 wins the first tie. The FSM resets to IDLE and counters to 0.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE:
  - If any req bit is high, grant one requester. With a single request, grant it. With both, grant the one not granted last.
  - On grant: latch that requester's mask into the remaining-mask register, set grant_id, set busy=1, go to SELECT.
- SELECT:
  - If the remaining mask is 0, go to DONE.
  - Otherwise pick the lowest set bit, clear it, drive that channel's o_dds_pwr_down high, load the counter, and go to PULSE.
- PULSE:
  - Exactly one o_dds_pwr_down bit is high; the others are 0.
  - After PULSE_CYCLES cycles of high output, drive all lines low and go to GAP. If GAP_CYCLES=0, go straight to SELECT.
- GAP: all lines low for GAP_CYCLES cycles, then go to SELECT.
- DONE: assert ack[grant_id] for one cycle, then go to IDLE. busy falls on the same edge that ack falls.
- Counter: 16-bit, loaded and compared against the parameter; there is no wrap-around.
- Requester rules:
  - Dropping req before grant withdraws the request.
  - Dropping req after grant is ignored; the sequence completes and ack is still issued.
  - The requester must deassert req in the cycle ack is high, otherwise IDLE treats it as a new request.
- Mask changes after grant have no effect.
- A request with an empty mask produces no pulses, only the ack.
- Reset asserted mid-operation drops all outputs to 0 immediately and discards the sequence; no ack is issued.

## Timing
- Let edge k be the IDLE edge that sees req high. busy=1 after edge k. The first o_dds_pwr_down bit goes high after edge k+1.
- Each selected channel is high for exactly PULSE_CYCLES cycles.
- The low interval between consecutive channels is GAP_CYCLES+1 cycles, because SELECT adds one cycle.
- For n selected channels, ack is high at cycle k + 2 + n·(PULSE_CYCLES+GAP_CYCLES+1) relative to edge k. With n=0, ack is high after edge k+2.
- All outputs are registered; nothing combinational passes from input to output.
- Minimum spacing between acks for back-to-back requests is 3 cycles (empty masks).

## Configuration
- DDS_PWR_ABORT_EN defined:
  - Adds the abort input and the aborted output.
  - abort high in PULSE, GAP or SELECT drives all o_dds_pwr_down low on the next edge, clears the remaining mask and goes to DONE.
  - In the ack cycle aborted=1. It holds until the next grant and is cleared on grant.
  - abort in IDLE or DONE is ignored.
- Not defined: the abort and aborted ports are absent and sequences always run to completion.

## Test plan
- Single channel: PULSE_CYCLES=4000, GAP_CYCLES=100, req=01, mask0=001 → DDS1 high for 4000 cycles starting 2 cycles after req; ack[0] 4103 cycles after the grant edge; busy low afterwards.
- Full sweep: mask1=111, req=10 → DDS1, DDS2, DDS3 pulsed in order, each 4000 cycles with 101 low cycles between; never two lines high at once; ack[1] once.
- Tie arbitration: req=11 from reset → requester 0 served first, then requester 1. On the next tie, requester 0 is served first again only because requester 1 was granted last.
- Empty mask and withdrawal: mask0=000 → ack[0] 2 cycles after grant with no pulses. Dropping req[1] before its grant → no ack[1].
- Reset mid-pulse: rst asserted during the DDS2 pulse → all outputs 0 asynchronously; after release the block is in IDLE with no ack.
- With DDS_PWR_ABORT_EN: abort during the DDS2 pulse of a 111 mask → lines low next edge, DDS3 never pulsed, ack with aborted=1.
